frame_dewhitener: RTL and testbench

- Receive-side stage that consumes the whitened word stream produced by the transmit whitener.
- Hunts for a sync word and captures a length header.
- De-whitens exactly that many payload words with the team's 16-bit whitening LFSR, reseeded per frame, then marks frame boundaries for the downstream packet parser.
- Streaming, no backpressure: one word per valid_i cycle, registered output.

---
 rtl/frame_dewhitener_pkg.sv | 18 +
 rtl/whiten_lfsr.sv | 41 ++++
 rtl/frame_dewhitener.sv | 139 +++++++++++++
 tb/tb_frame_dewhitener.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_dewhitener_pkg.sv
// Shared types and constants for the receive-side frame de-whitener and
// the whitening LFSR it shares with the transmit side.
package frame_dewhitener_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_SEED    = 16'hFFFF;
  localparam int          TAP_A        = 15;
  localparam int          TAP_B        = 4;
  localparam int          TAP_C        = 1;
  localparam int          TAP_D        = 0;
  localparam logic [31:0] SYNC_DEFAULT = 32'h1ACFFC1D;

endpackage

// File: rtl/whiten_lfsr.sv
// Whitening LFSR: reseeds to all ones on seed_load, steps on advance.
// mask_bit is the mask for the word currently being processed.
module whiten_lfsr
  import frame_dewhitener_pkg::*;
#(
  parameter int LFSR_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic seed_load,
  input  logic advance,
  output logic mask_bit
);

  localparam logic [LFSR_W-1:0] SEED = LFSR_W'(LFSR_SEED);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic              fb;

  always_comb begin
    fb     = lfsr_q[TAP_A] ^ lfsr_q[TAP_B] ^ lfsr_q[TAP_C] ^ lfsr_q[TAP_D];
    lfsr_d = lfsr_q;
    // A reseed wins over an advance so every frame starts from the seed.
    if (seed_load) begin
      lfsr_d = SEED;
    end else if (advance) begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], fb};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign mask_bit = lfsr_q[0];

endmodule

// File: rtl/frame_dewhitener.sv
// Receive stage: hunts for sync, takes a length header, de-whitens that many
// payload words and flags first/last word. Handshake: valid_i strobes one
// word per cycle with no backpressure; valid_o qualifies d_o/sof_o/eof_o.
module frame_dewhitener
  import frame_dewhitener_pkg::*;
#(
  parameter int          W       = 32,
  parameter int          LFSR_W  = 16,
  parameter logic [31:0] SYNC    = SYNC_DEFAULT,
  parameter int          MAX_LEN = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_i,
  input  logic [W-1:0] d_i,
  output logic         valid_o,
  output logic [W-1:0] d_o,
  output logic         sof_o,
  output logic         eof_o,
  output logic         hdr_err_o,
  output logic         locked_o,
  output logic [15:0]  frame_cnt_o
);

  localparam logic [W-1:0] SYNC_W    = W'(SYNC);
  localparam logic [15:0]  MAX_LEN_L = 16'(MAX_LEN);

  state_e         state_q, state_d;
  logic [15:0]    len_q, len_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           valid_q, valid_d;
  logic [W-1:0]   dout_q, dout_d;
  logic           sof_q, sof_d;
  logic           eof_q, eof_d;
  logic           hdr_err_q, hdr_err_d;
  logic           locked_q, locked_d;
  logic [15:0]    frame_cnt_q, frame_cnt_d;

  logic           seed_load;
  logic           advance;
  logic           mask_bit;
  logic [15:0]    hdr_len;
  logic [15:0]    cnt_inc;
  logic           last_word;

  whiten_lfsr #(.LFSR_W(LFSR_W)) u_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (seed_load),
    .advance   (advance),
    .mask_bit  (mask_bit)
  );

  assign hdr_len   = d_i[15:0];
  assign cnt_inc   = cnt_q + 16'd1;
  assign last_word = (cnt_inc == len_q);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    valid_d     = 1'b0;
    dout_d      = dout_q;
    sof_d       = 1'b0;
    eof_d       = 1'b0;
    hdr_err_d   = 1'b0;
    frame_cnt_d = frame_cnt_q;
    seed_load   = 1'b0;
    advance     = 1'b0;
    if (valid_i) begin
      case (state_q)
        HUNT: begin
          if (d_i == SYNC_W) state_d = HDR;
        end
        HDR: begin
          // The header is never whitened and is never re-checked for sync.
          if (hdr_len == 16'd0 || hdr_len > MAX_LEN_L) begin
            hdr_err_d = 1'b1;
            state_d   = HUNT;
          end else begin
            len_d     = hdr_len;
            cnt_d     = 16'd0;
            seed_load = 1'b1;
            state_d   = PAYLOAD;
          end
        end
        PAYLOAD: begin
          valid_d = 1'b1;
          dout_d  = d_i ^ {W{mask_bit}};
          sof_d   = (cnt_q == 16'd0);
          eof_d   = last_word;
          cnt_d   = cnt_inc;
          advance = 1'b1;
          if (last_word) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    locked_d = (state_d == HDR) || (state_d == PAYLOAD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      len_q       <= 16'd0;
      cnt_q       <= 16'd0;
      valid_q     <= 1'b0;
      dout_q      <= '0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      hdr_err_q   <= 1'b0;
      locked_q    <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      dout_q      <= dout_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      hdr_err_q   <= hdr_err_d;
      locked_q    <= locked_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign valid_o     = valid_q;
  assign d_o         = dout_q;
  assign sof_o       = sof_q;
  assign eof_o       = eof_q;
  assign hdr_err_o   = hdr_err_q;
  assign locked_o    = locked_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_frame_dewhitener.sv
// Bench for frame_dewhitener: cycle-exact vector table for the directed
// cases, then random frames whitened by the bench and decoded back.
module tb_frame_dewhitener;

  localparam int          W     = 32;
  localparam logic [31:0] SYNCW = 32'h1ACFFC1D;

  logic         clk;
  logic         rst_n;
  logic         valid_i;
  logic [W-1:0] d_i;
  logic         valid_o;
  logic [W-1:0] d_o;
  logic         sof_o;
  logic         eof_o;
  logic         hdr_err_o;
  logic         locked_o;
  logic [15:0]  frame_cnt_o;

  frame_dewhitener #(.W(W), .LFSR_W(16), .SYNC(SYNCW), .MAX_LEN(1024)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_i     (valid_i),
    .d_i         (d_i),
    .valid_o     (valid_o),
    .d_o         (d_o),
    .sof_o       (sof_o),
    .eof_o       (eof_o),
    .hdr_err_o   (hdr_err_o),
    .locked_o    (locked_o),
    .frame_cnt_o (frame_cnt_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         e_v;
    logic [W-1:0] e_d;
    logic         e_sof;
    logic         e_eof;
    logic         e_err;
    logic         e_lock;
    logic [15:0]  e_fc;
  } vec_t;

  vec_t         tab[$];
  logic [W+1:0] exp_q[$];
  logic         mask_tab[1024];
  int           checks;
  int           errors;
  int           exp_err;
  int           act_err;
  logic [15:0]  exp_fc;
  logic         mon_en;

  task automatic add(input logic v, input logic [W-1:0] d, input logic e_v,
                     input logic [W-1:0] e_d, input logic e_sof, input logic e_eof,
                     input logic e_err, input logic e_lock, input logic [15:0] e_fc);
    vec_t r;
    r.v = v; r.d = d; r.e_v = e_v; r.e_d = e_d; r.e_sof = e_sof;
    r.e_eof = e_eof; r.e_err = e_err; r.e_lock = e_lock; r.e_fc = e_fc;
    tab.push_back(r);
  endtask

  // Mask for payload word k of any frame, straight from the LFSR definition.
  task automatic build_masks();
    logic [15:0] s;
    s = 16'hFFFF;
    for (int k = 0; k < 1024; k++) begin
      mask_tab[k] = s[0];
      s = {s[14:0], s[15] ^ s[4] ^ s[1] ^ s[0]};
    end
  endtask

  // scoreboard: consume one observed output cycle
  task automatic monitor();
    logic [W+1:0] e;
    if (hdr_err_o) act_err++;
    if (valid_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out got d=%h sof=%b eof=%b want none", d_o, sof_o, eof_o);
      end else begin
        e = exp_q.pop_front();
        if ({sof_o, eof_o, d_o} !== e) begin
          errors++;
          $display("FAIL payload got sof=%b eof=%b d=%h want sof=%b eof=%b d=%h",
                   sof_o, eof_o, d_o, e[W+1], e[W], e[W-1:0]);
        end
      end
    end
  endtask

  // driver: present one cycle, sample #1 after the edge
  task automatic step(input logic v, input logic [W-1:0] d);
    valid_i = v;
    d_i     = d;
    @(posedge clk);
    #1;
    if (mon_en) monitor();
  endtask

  task automatic maybe_gap();
    if ($urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 2)) step(1'b0, $urandom);
    end
  endtask

  task automatic send_word(input logic [W-1:0] d);
    maybe_gap();
    step(1'b1, d);
  endtask

  task automatic send_frame(input int len);
    logic [W-1:0] wire_w;
    logic [W-1:0] plain;
    send_word(SYNCW);
    send_word({$urandom_range(0, 65535), 16'(len)});
    for (int k = 0; k < len; k++) begin
      plain  = $urandom;
      wire_w = plain ^ {W{mask_tab[k]}};
      if ($urandom_range(0, 7) == 0) begin
        wire_w = SYNCW;
        plain  = SYNCW ^ {W{mask_tab[k]}};
      end
      exp_q.push_back({(k == 0), (k == len - 1), plain});
      send_word(wire_w);
    end
    exp_fc++;
  endtask

  task automatic send_bad_hdr();
    logic [15:0] bad;
    bad = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(1025, 65535));
    send_word(SYNCW);
    send_word({$urandom_range(0, 65535), bad});
    exp_err++;
  endtask

  task automatic check_vec(input string name, input logic [W+19:0] act, input logic [W+19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    logic [W-1:0] junk;
    checks  = 0;
    errors  = 0;
    exp_err = 0;
    act_err = 0;
    exp_fc  = 16'd0;
    mon_en  = 1'b0;
    rst_n   = 1'b0;
    valid_i = 1'b0;
    d_i     = '0;
    build_masks();

    // basic frame
    add(1, SYNCW,        0, 32'h0,        0, 0, 0, 1, 0);
    add(1, 32'h4,        0, 32'h0,        0, 0, 0, 1, 0);
    add(1, 32'hEDCBA987, 1, 32'h12345678, 1, 0, 0, 1, 0);
    add(1, 32'h12345678, 1, 32'h12345678, 0, 0, 0, 1, 0);
    add(1, 32'hEDCBA987, 1, 32'h12345678, 0, 0, 0, 1, 0);
    add(1, 32'hEDCBA987, 1, 32'h12345678, 0, 1, 0, 0, 1);
    // gapped copy, idle data ignored
    add(0, 32'hFFFFFFFF, 0, 32'h12345678, 0, 0, 0, 0, 1);
    add(1, SYNCW,        0, 32'h12345678, 0, 0, 0, 1, 1);
    add(0, SYNCW,        0, 32'h12345678, 0, 0, 0, 1, 1);
    add(1, 32'h4,        0, 32'h12345678, 0, 0, 0, 1, 1);
    add(0, 32'h0,        0, 32'h12345678, 0, 0, 0, 1, 1);
    add(1, 32'hEDCBA987, 1, 32'h12345678, 1, 0, 0, 1, 1);
    add(0, 32'h0,        0, 32'h12345678, 0, 0, 0, 1, 1);
    add(1, 32'h12345678, 1, 32'h12345678, 0, 0, 0, 1, 1);
    add(0, 32'h0,        0, 32'h12345678, 0, 0, 0, 1, 1);
    add(1, 32'hEDCBA987, 1, 32'h12345678, 0, 0, 0, 1, 1);
    add(0, 32'h0,        0, 32'h12345678, 0, 0, 0, 1, 1);
    add(1, 32'hEDCBA987, 1, 32'h12345678, 0, 1, 0, 0, 2);
    // bad headers: zero, MAX_LEN+1, and a header equal to sync (0xFC1D)
    add(1, SYNCW,        0, 32'h12345678, 0, 0, 0, 1, 2);
    add(1, 32'h0,        0, 32'h12345678, 0, 0, 1, 0, 2);
    add(1, SYNCW,        0, 32'h12345678, 0, 0, 0, 1, 2);
    add(1, 32'h401,      0, 32'h12345678, 0, 0, 1, 0, 2);
    add(1, SYNCW,        0, 32'h12345678, 0, 0, 0, 1, 2);
    add(1, SYNCW,        0, 32'h12345678, 0, 0, 1, 0, 2);
    // junk before sync, len 1
    add(1, 32'hDEADBEEF, 0, 32'h12345678, 0, 0, 0, 0, 2);
    add(1, 32'h0,        0, 32'h12345678, 0, 0, 0, 0, 2);
    add(1, SYNCW,        0, 32'h12345678, 0, 0, 0, 1, 2);
    add(1, 32'h1,        0, 32'h12345678, 0, 0, 0, 1, 2);
    add(1, 32'hFFFFFFFF, 1, 32'h00000000, 1, 1, 0, 0, 3);
    // back-to-back len 2 frames, sync pattern as payload data
    add(1, SYNCW,        0, 32'h0,        0, 0, 0, 1, 3);
    add(1, 32'h2,        0, 32'h0,        0, 0, 0, 1, 3);
    add(1, 32'h0000FFFF, 1, 32'hFFFF0000, 1, 0, 0, 1, 3);
    add(1, 32'h13579BDF, 1, 32'h13579BDF, 0, 1, 0, 0, 4);
    add(1, SYNCW,        0, 32'h13579BDF, 0, 0, 0, 1, 4);
    add(1, 32'h2,        0, 32'h13579BDF, 0, 0, 0, 1, 4);
    add(1, 32'hA5A5A5A5, 1, 32'h5A5A5A5A, 1, 0, 0, 1, 4);
    add(1, SYNCW,        1, SYNCW,        0, 1, 0, 0, 5);

    repeat (2) @(posedge clk);
    #1;
    check_vec("reset_state",
              {valid_o, d_o, sof_o, eof_o, hdr_err_o, locked_o, frame_cnt_o},
              {1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0});
    rst_n = 1'b1;

    for (int i = 0; i < tab.size(); i++) begin
      step(tab[i].v, tab[i].d);
      check_vec($sformatf("vec%0d", i),
                {valid_o, d_o, sof_o, eof_o, hdr_err_o, locked_o, frame_cnt_o},
                {tab[i].e_v, tab[i].e_d, tab[i].e_sof, tab[i].e_eof,
                 tab[i].e_err, tab[i].e_lock, tab[i].e_fc});
    end

    // reset in the middle of a payload
    step(1'b1, SYNCW);
    step(1'b1, 32'h4);
    step(1'b1, 32'hEDCBA987);
    check_vec("pre_reset_sof", {20'h0, valid_o, sof_o, d_o[29:0]},
              {20'h0, 1'b1, 1'b1, 30'h12345678});
    rst_n = 1'b0;
    step(1'b1, 32'h12345678);
    check_vec("mid_frame_reset",
              {valid_o, d_o, sof_o, eof_o, hdr_err_o, locked_o, frame_cnt_o},
              {1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0});
    rst_n = 1'b1;
    step(1'b1, 32'hEDCBA987);
    step(1'b1, 32'hEDCBA987);
    check_vec("after_reset_quiet", {W'(0), 17'h0, valid_o, eof_o, locked_o},
              {W'(0), 17'h0, 3'b000});

    // random frames against the bench model
    mon_en = 1'b1;
    send_frame(4);
    for (int f = 0; f < 30; f++) begin
      repeat ($urandom_range(0, 2)) begin
        junk = $urandom;
        if (junk == SYNCW) junk = junk ^ 32'h1;
        send_word(junk);
      end
      if ($urandom_range(0, 3) == 0) send_bad_hdr();
      send_frame($urandom_range(1, 12));
    end
    send_frame(1024);
    repeat (3) step(1'b0, '0);
    mon_en = 1'b0;

    check_vec("exp_q_drained", {W'(0), 20'(exp_q.size())}, {W'(0), 20'h0});
    check_vec("frame_cnt", {W'(0), 4'h0, frame_cnt_o}, {W'(0), 4'h0, exp_fc});
    check_vec("hdr_err_count", {W'(0), 20'(act_err)}, {W'(0), 20'(exp_err)});
    check_vec("idle_locked", {W'(0), 19'h0, locked_o}, {W'(0), 20'h0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
